// File: rtl/br_tag_ctrl.sv
// br_tag_ctrl
//   Allocates one-hot branch tags at dispatch, tracks relative age of the
//   outstanding branches, and on resolution frees the resolved tag (correct
//   prediction) or the tag plus every younger tag (misprediction). The
//   registered clear/recover pulses are broadcast to all br_mask holders.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   alloc_req_i         dispatch wants a tag this cycle
//   alloc_gnt_o         combinational grant (tag live from next edge)
//   alloc_tag_1hot_o    combinational lowest free tag (0 when full)
//   live_mask_o         registered mask of outstanding tags
//   stall_o             combinational: full, recovering, or mispredict now
//   br_right_i          resolving branch was predicted correctly
//   br_wrong_i          resolving branch was mispredicted
//   br_tag_1hot_i       tag of the resolving branch
//   clear_o/clear_tag_o registered one-cycle clear pulse and its tag
//   recover_o           registered one-cycle recovery pulse
//   recover_mask_o      registered squash mask (mispredicted tag + younger)
//   live_cnt_o          popcount of live_mask_o
//
// state   | meaning
// NORMAL  | tags may be allocated, wrong/right resolves accepted
// RECOVER | one cycle after a squash; no allocation, wrong ignored
module br_tag_ctrl #(
  parameter int BR_MASK_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_req_i,
  output logic                           alloc_gnt_o,
  output logic [BR_MASK_W-1:0]           alloc_tag_1hot_o,
  output logic [BR_MASK_W-1:0]           live_mask_o,
  output logic                           stall_o,
  input  logic                           br_right_i,
  input  logic                           br_wrong_i,
  input  logic [BR_MASK_W-1:0]           br_tag_1hot_i,
  output logic                           clear_o,
  output logic [BR_MASK_W-1:0]           clear_tag_o,
  output logic                           recover_o,
  output logic [BR_MASK_W-1:0]           recover_mask_o,
  output logic [$clog2(BR_MASK_W+1)-1:0] live_cnt_o
);

  localparam int CNT_W = $clog2(BR_MASK_W + 1);

  typedef enum logic {NORMAL, RECOVER} state_t;

  state_t               state_q, state_d;
  logic [BR_MASK_W-1:0] live_q, live_d;
  // dep_q[i] holds the tags that were live (older) when tag i was allocated
  logic [BR_MASK_W-1:0] dep_q [BR_MASK_W];
  logic [BR_MASK_W-1:0] dep_d [BR_MASK_W];
  logic                 clear_q, recover_q;
  logic [BR_MASK_W-1:0] clear_tag_q, recover_mask_q;

  logic                 in_normal, full, found, tag_live;
  logic                 wrong_acc, right_acc;
  logic [BR_MASK_W-1:0] free_tag, younger, kill, freed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= NORMAL;
      live_q         <= '0;
      for (int i = 0; i < BR_MASK_W; i++) dep_q[i] <= '0;
      clear_q        <= 1'b0;
      clear_tag_q    <= '0;
      recover_q      <= 1'b0;
      recover_mask_q <= '0;
    end else begin
      state_q        <= state_d;
      live_q         <= live_d;
      for (int i = 0; i < BR_MASK_W; i++) dep_q[i] <= dep_d[i];
      clear_q        <= right_acc;
      clear_tag_q    <= right_acc ? br_tag_1hot_i : '0;
      recover_q      <= wrong_acc;
      recover_mask_q <= wrong_acc ? kill : '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    live_d   = live_q;
    free_tag = '0;
    found    = 1'b0;
    younger  = '0;
    for (int i = 0; i < BR_MASK_W; i++) dep_d[i] = dep_q[i];

    for (int i = 0; i < BR_MASK_W; i++) begin
      if (!live_q[i] && !found) begin
        free_tag[i] = 1'b1;
        found       = 1'b1;
      end
    end

    in_normal   = (state_q == NORMAL);
    full        = &live_q;
    alloc_gnt_o = alloc_req_i && !full && in_normal && !br_wrong_i;
    stall_o     = full || !in_normal || br_wrong_i;
    alloc_tag_1hot_o = free_tag;

    tag_live  = |(br_tag_1hot_i & live_q);
    wrong_acc = br_wrong_i && in_normal && tag_live;
    for (int j = 0; j < BR_MASK_W; j++)
      younger[j] = live_q[j] && |(dep_q[j] & br_tag_1hot_i);
    kill = br_tag_1hot_i | younger;

    // while recovering, a right on an already-squashed tag must not pulse
    right_acc = br_right_i && !wrong_acc && tag_live &&
                !(!in_normal && |(br_tag_1hot_i & recover_mask_q));

    freed = wrong_acc ? kill : (right_acc ? br_tag_1hot_i : '0);

    live_d = (live_q & ~freed) | (alloc_gnt_o ? free_tag : '0);

    for (int i = 0; i < BR_MASK_W; i++) begin
      if (wrong_acc && kill[i])
        dep_d[i] = '0;
      else
        dep_d[i] = dep_q[i] & ~freed;
      // the new row drops a tag freed this same cycle so that a later
      // reuse of that tag is not mistaken for an older branch
      if (alloc_gnt_o && free_tag[i])
        dep_d[i] = live_q & ~freed;
    end

    case (state_q)
      NORMAL:  if (wrong_acc) state_d = RECOVER;
      RECOVER: state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    live_cnt_o = '0;
    for (int i = 0; i < BR_MASK_W; i++)
      live_cnt_o = live_cnt_o + CNT_W'(live_q[i]);
  end

  assign live_mask_o    = live_q;
  assign clear_o        = clear_q;
  assign clear_tag_o    = clear_tag_q;
  assign recover_o      = recover_q;
  assign recover_mask_o = recover_mask_q;

endmodule

// File: tb/tb_br_tag_ctrl.sv
// Bench for br_tag_ctrl: directed scenarios plus randomized traffic, checked
// against an age-ordered list model of the outstanding branches.
module tb_br_tag_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, alloc_req_i, br_right_i, br_wrong_i;
  logic [W-1:0] br_tag_1hot_i;
  logic         alloc_gnt_o, stall_o, clear_o, recover_o;
  logic [W-1:0] alloc_tag_1hot_o, live_mask_o, clear_tag_o, recover_mask_o;
  logic [2:0]   live_cnt_o;

  br_tag_ctrl #(.BR_MASK_W(W)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o),
    .alloc_tag_1hot_o(alloc_tag_1hot_o), .live_mask_o(live_mask_o),
    .stall_o(stall_o), .br_right_i(br_right_i), .br_wrong_i(br_wrong_i),
    .br_tag_1hot_i(br_tag_1hot_i), .clear_o(clear_o), .clear_tag_o(clear_tag_o),
    .recover_o(recover_o), .recover_mask_o(recover_mask_o),
    .live_cnt_o(live_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: outstanding tag indices, oldest first
  int         order[$];
  bit         m_rec, m_clear, m_recov;
  logic [W-1:0] m_clear_tag, m_rec_mask;

  logic       obs_gnt, obs_stall;
  logic [W-1:0] obs_tag;

  function automatic logic [W-1:0] m_live();
    logic [W-1:0] m;
    m = '0;
    foreach (order[k]) m[order[k]] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    order.delete();
    m_rec = 0; m_clear = 0; m_recov = 0;
    m_clear_tag = '0; m_rec_mask = '0;
  endtask

  task automatic step(input bit r, input bit req, input bit right, input bit wrong,
                      input logic [W-1:0] t);
    logic [W-1:0] live, ex_tag, kmask;
    bit ex_gnt, full, wacc, racc;
    int ex_idx, pos;
    rst = r; alloc_req_i = req; br_right_i = right; br_wrong_i = wrong;
    br_tag_1hot_i = t;
    #1;
    live   = m_live();
    full   = (order.size() == W);
    ex_tag = '0;
    ex_idx = -1;
    for (int i = 0; i < W; i++)
      if (!live[i] && ex_idx < 0) begin ex_tag[i] = 1'b1; ex_idx = i; end
    ex_gnt = req && !full && !m_rec && !wrong;
    check("gnt",   32'(alloc_gnt_o), 32'(ex_gnt));
    check("tag",   32'(alloc_tag_1hot_o), 32'(ex_tag));
    check("stall", 32'(stall_o), 32'(full || m_rec || wrong));
    obs_gnt = alloc_gnt_o; obs_tag = alloc_tag_1hot_o; obs_stall = stall_o;

    wacc = wrong && !m_rec && ((t & live) != 0);
    racc = right && !wacc && ((t & live) != 0) && !(m_rec && ((t & m_rec_mask) != 0));
    m_clear = racc; m_clear_tag = racc ? t : '0;
    m_recov = wacc; m_rec_mask = '0;
    if (wacc) begin
      pos = 0;
      foreach (order[k]) if (W'(1 << order[k]) == t) pos = k;
      kmask = '0;
      while (order.size() > pos) kmask[order.pop_back()] = 1'b1;
      m_rec_mask = kmask;
    end
    if (racc) begin
      pos = 0;
      foreach (order[k]) if (W'(1 << order[k]) == t) pos = k;
      order.delete(pos);
    end
    if (ex_gnt) order.push_back(ex_idx);
    m_rec = wacc;
    if (r) model_reset();

    @(posedge clk); #1;
    check("live",      32'(live_mask_o), 32'(m_live()));
    check("cnt",       32'(live_cnt_o), 32'(order.size()));
    check("clear",     32'(clear_o), 32'(m_clear));
    check("clear_tag", 32'(clear_tag_o), 32'(m_clear_tag));
    check("recover",   32'(recover_o), 32'(m_recov));
    check("rec_mask",  32'(recover_mask_o), 32'(m_rec_mask));
  endtask

  task automatic idle();  step(0, 0, 0, 0, '0); endtask
  task automatic alloc(); step(0, 1, 0, 0, '0); endtask
  task automatic do_rst(); step(1, 0, 0, 0, '0); endtask

  initial begin
    logic [W-1:0] t, lv;
    rst = 1; alloc_req_i = 0; br_right_i = 0; br_wrong_i = 0; br_tag_1hot_i = '0;
    @(posedge clk); #1;
    model_reset();
    check("rst_live",  32'(live_mask_o), 0);
    check("rst_cnt",   32'(live_cnt_o), 0);
    check("rst_clr",   32'(clear_o), 0);
    check("rst_rec",   32'(recover_o), 0);
    check("rst_rmask", 32'(recover_mask_o), 0);

    // fill all four tags, fifth request stalls
    do_rst();
    alloc(); check("s1_t0", 32'(obs_tag), 32'h1);
    alloc(); check("s1_t1", 32'(obs_tag), 32'h2);
    alloc(); check("s1_t2", 32'(obs_tag), 32'h4);
    alloc(); check("s1_t3", 32'(obs_tag), 32'h8);
    check("s1_live", 32'(live_mask_o), 32'hF);
    check("s1_cnt",  32'(live_cnt_o), 4);
    alloc(); check("s1_stall", 32'(obs_stall), 1); check("s1_nogrant", 32'(obs_gnt), 0);

    // correct resolve, then mispredict of oldest
    do_rst(); alloc(); alloc(); alloc();
    step(0, 0, 1, 0, 4'b0010);
    check("s2_clr", 32'(clear_o), 1);
    check("s2_ctag", 32'(clear_tag_o), 32'h2);
    check("s2_live", 32'(live_mask_o), 32'h5);
    step(0, 0, 0, 1, 4'b0001);
    check("s2_rmask", 32'(recover_mask_o), 32'h5);
    idle();

    // mispredict mid-age, allocation blocked two cycles
    do_rst(); alloc(); alloc(); alloc(); alloc();
    step(0, 1, 0, 1, 4'b0010);
    check("s3_gnt_n", 32'(obs_gnt), 0);
    check("s3_rec", 32'(recover_o), 1);
    check("s3_rmask", 32'(recover_mask_o), 32'hE);
    check("s3_live", 32'(live_mask_o), 32'h1);
    alloc(); check("s3_gnt_n1", 32'(obs_gnt), 0);
    alloc(); check("s3_gnt_n2", 32'(obs_gnt), 1); check("s3_tag", 32'(obs_tag), 32'h2);

    // full mask: right + alloc same cycle
    do_rst(); alloc(); alloc(); alloc(); alloc();
    step(0, 1, 1, 0, 4'b0100);
    check("s4_stall", 32'(obs_stall), 1);
    alloc(); check("s4_gnt", 32'(obs_gnt), 1); check("s4_tag", 32'(obs_tag), 32'h4);

    // wrong beats right; dead-tag resolves ignored
    do_rst(); alloc(); alloc(); alloc(); alloc();
    br_right_i = 1;
    step(0, 0, 1, 1, 4'b0100);  // both asserted, tag shared: wrong wins
    check("s5_clr", 32'(clear_o), 0);
    check("s5_rec", 32'(recover_o), 1);
    check("s5_rmask", 32'(recover_mask_o), 32'hC);
    idle();
    step(0, 0, 0, 1, 4'b1000); check("s5_dead_w", 32'(recover_o), 0);
    step(0, 0, 1, 0, 4'b1000); check("s5_dead_r", 32'(clear_o), 0);
    check("s5_live", 32'(live_mask_o), 32'h3);

    // reset during RECOVER
    do_rst(); alloc(); alloc();
    step(0, 0, 0, 1, 4'b0001);
    do_rst();
    check("s6_rec", 32'(recover_o), 0);
    check("s6_rmask", 32'(recover_mask_o), 0);
    check("s6_live", 32'(live_mask_o), 0);
    alloc(); check("s6_gnt", 32'(obs_gnt), 1); check("s6_tag", 32'(obs_tag), 32'h1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      lv = m_live();
      t = W'(1 << $urandom_range(0, W-1));
      for (int k = 0; k < 3; k++)
        if ((t & lv) == 0) t = W'(1 << $urandom_range(0, W-1));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
